// File: rtl/rom_read_responder.sv
// rom_read_responder
//
// Table-side responder for the ce/addr/data_valid read handshake. Holds a
// 2^ADDR_W x DATA_W table that the loader writes through wr_en/wr_addr/wr_data.
// It serves one outstanding read at a time and answers with a one-cycle
// data_valid pulse RD_LAT cycles after the request is accepted.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset (control and output registers)
//   ce          read request, held high by the requester until data_valid
//   addr        read address, stable while ce is high
//   wr_en       table write strobe, honoured in every state
//   wr_addr     table write address
//   wr_data     table write data
//   data_out    returned word, updated only in the response cycle and held
//   data_valid  one-cycle response pulse
//   busy        request accepted but not yet answered
//   resp_cnt    responses issued, saturating at 16'hFFFF
//
// RD_LAT must lie in 1..7.

module rom_read_responder #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ce,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic [15:0]       resp_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      READ     = 2'd1,
      RESP     = 2'd2,
      WAIT_LOW = 2'd3
   } state_t;

   // Counter value of the last READ cycle before the response.
   localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic [15:0]       resp_cnt_q, resp_cnt_d;
   logic [DATA_W-1:0] data_out_q;
   logic [DATA_W-1:0] rdata_q;
   logic              accept;
   logic              load_out;

   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

   // ---------------------------------------------------------------
   // Control state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         resp_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         resp_cnt_q <= resp_cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // Next-state and output decode
   // ---------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      resp_cnt_d = resp_cnt_q;
      accept     = 1'b0;
      load_out   = 1'b0;

      case (state_q)
         IDLE: begin
            if (ce) begin
               accept = 1'b1;
               cnt_d  = 3'd1;
               if (RD_LAT == 1) begin
                  // Single-cycle latency: respond straight away, busy never rises.
                  state_d  = RESP;
                  valid_d  = 1'b1;
                  load_out = 1'b1;
                  busy_d   = 1'b0;
               end else begin
                  state_d = READ;
                  busy_d  = 1'b1;
               end
            end
         end
         READ: begin
            // A dropped request wins over a response due this cycle.
            if (!ce) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = 3'd0;
            end else if (cnt_q == LAST_CNT) begin
               state_d  = RESP;
               valid_d  = 1'b1;
               load_out = 1'b1;
               busy_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         RESP: begin
            // The pulse is already committed; ce falling here does not matter.
            state_d = WAIT_LOW;
         end
         WAIT_LOW: begin
            // A new read needs ce to have been low for at least one cycle.
            if (!ce) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (load_out && (resp_cnt_q != 16'hFFFF)) resp_cnt_d = resp_cnt_q + 16'd1;
   end

   // ---------------------------------------------------------------
   // Table memory: write port plus registered read at acceptance.
   // Non-blocking update gives read-first behaviour on a same-cycle write.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (accept) rdata_q <= mem[addr];
   end

   // ---------------------------------------------------------------
   // Response word register; with RD_LAT=1 the table word goes straight
   // to the output register since there is no intermediate cycle.
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out_q <= '0;
      end else if (load_out) begin
         data_out_q <= (RD_LAT == 1) ? mem[addr] : rdata_q;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = valid_q;
   assign busy       = busy_q;
   assign resp_cnt   = resp_cnt_q;

endmodule

// File: tb/tb_rom_read_responder.sv
// tb_rom_read_responder
//
// Drives four responder instances (RD_LAT = 1, 2, 4, 7), each with its own
// input set, and compares them against a transaction-level model: a shadow
// copy of each table, the word snapshot at request time, the expected
// response cycle, the last returned word and a saturating response count.

module tb_rom_read_responder;

   localparam int N = 4;
   localparam int LATS [N] = '{1, 2, 4, 7};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n      [N];
   logic        ce         [N];
   logic [7:0]  addr       [N];
   logic        wr_en      [N];
   logic [7:0]  wr_addr    [N];
   logic [31:0] wr_data    [N];
   logic [31:0] data_out   [N];
   logic        data_valid [N];
   logic        busy       [N];
   logic [15:0] resp_cnt   [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      rom_read_responder #(.DATA_W(32), .ADDR_W(8), .RD_LAT(LATS[g])) u (
         .clk        (clk),
         .rst_n      (rst_n[g]),
         .ce         (ce[g]),
         .addr       (addr[g]),
         .wr_en      (wr_en[g]),
         .wr_addr    (wr_addr[g]),
         .wr_data    (wr_data[g]),
         .data_out   (data_out[g]),
         .data_valid (data_valid[g]),
         .busy       (busy[g]),
         .resp_cnt   (resp_cnt[g])
      );
   end

   // Reference model state
   logic [31:0] mdl [N][256];
   int          expcnt [N];
   logic [31:0] prev [N];
   int          total = 0;
   int          bad = 0;

   typedef struct {
      int          k;
      logic [7:0]  a;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s dut%0d got=%h want=%h", nm, k, act, exp);
      end
   endtask

   task automatic wr(input int k, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_en[k] = 1'b1; wr_addr[k] = a; wr_data[k] = d;
      mdl[k][a] = d;
      @(posedge clk);
      #1;
      wr_en[k] = 1'b0;
   endtask

   // Write slot helper: wd0 at cycle index wat, wd1 at wat+1 (wat<0: none).
   task automatic drive_wr(input int k, input int i, input int wat, input logic [7:0] wa,
                           input logic [31:0] wd0, input logic [31:0] wd1);
      wr_en[k] = 1'b0;
      if (wat >= 0 && i == wat) begin
         wr_en[k] = 1'b1; wr_addr[k] = wa; wr_data[k] = wd0; mdl[k][wa] = wd0;
      end else if (wat >= 0 && i == wat + 1) begin
         wr_en[k] = 1'b1; wr_addr[k] = wa; wr_data[k] = wd1; mdl[k][wa] = wd1;
      end
   endtask

   // One complete request: ce held for `hold` extra cycles after the pulse,
   // then low for one cycle before the caller may start the next request.
   task automatic rd(input int k, input logic [7:0] a, input int hold, input int wat,
                     input logic [7:0] wa, input logic [31:0] wd0, input logic [31:0] wd1);
      int lat;
      logic [31:0] exp;
      lat = LATS[k];
      @(negedge clk);
      exp = mdl[k][a];
      ce[k] = 1'b1; addr[k] = a;
      drive_wr(k, 0, wat, wa, wd0, wd1);
      for (int i = 1; i <= lat + 1 + hold; i++) begin
         @(negedge clk);
         if (i == lat) begin
            expcnt[k] = (expcnt[k] < 65535) ? expcnt[k] + 1 : 65535;
            prev[k]   = exp;
         end
         chk("data_valid", k, 32'(data_valid[k]), 32'(i == lat));
         chk("data_out", k, data_out[k], prev[k]);
         chk("resp_cnt", k, 32'(resp_cnt[k]), 32'(expcnt[k]));
         chk("busy", k, 32'(busy[k]), 32'(i < lat));
         drive_wr(k, i, wat, wa, wd0, wd1);
         if (i == lat + 1 + hold) ce[k] = 1'b0;
      end
   endtask

   // Request that is dropped at cycle T+drop (drop>0) or cut by reset
   // asserted at cycle T+rstc (rstc>0, ce held).
   task automatic ab(input int k, input logic [7:0] a, input int drop, input int rstc);
      int lat;
      lat = LATS[k];
      @(negedge clk);
      ce[k] = 1'b1; addr[k] = a;
      for (int i = 1; i <= lat + 2; i++) begin
         @(negedge clk);
         if (rstc > 0 && i == rstc + 1) begin
            expcnt[k] = 0;
            prev[k]   = 32'd0;
            chk("rst_data_valid", k, 32'(data_valid[k]), 32'd0);
            chk("rst_busy", k, 32'(busy[k]), 32'd0);
            chk("rst_data_out", k, data_out[k], 32'd0);
            chk("rst_resp_cnt", k, 32'(resp_cnt[k]), 32'd0);
            rst_n[k] = 1'b1;
            ce[k]    = 1'b0;
            break;
         end
         chk("ab_data_valid", k, 32'(data_valid[k]), 32'd0);
         chk("ab_data_out", k, data_out[k], prev[k]);
         chk("ab_resp_cnt", k, 32'(resp_cnt[k]), 32'(expcnt[k]));
         chk("ab_busy", k, 32'(busy[k]), (drop > 0) ? 32'(i <= drop) : 32'd1);
         if (i == drop) ce[k] = 1'b0;
         if (i == rstc) rst_n[k] = 1'b0;
      end
   endtask

   initial begin
      int          k;
      int          hold;
      int          wat;
      logic [7:0]  a;
      logic [7:0]  wa;

      for (int j = 0; j < N; j++) begin
         rst_n[j] = 1'b0; ce[j] = 1'b0; addr[j] = 8'd0;
         wr_en[j] = 1'b0; wr_addr[j] = 8'd0; wr_data[j] = 32'd0;
         expcnt[j] = 0; prev[j] = 32'd0;
      end
      repeat (3) @(negedge clk);
      for (int j = 0; j < N; j++) begin
         chk("reset_data_valid", j, 32'(data_valid[j]), 32'd0);
         chk("reset_busy", j, 32'(busy[j]), 32'd0);
         chk("reset_data_out", j, data_out[j], 32'd0);
         chk("reset_resp_cnt", j, 32'(resp_cnt[j]), 32'd0);
         rst_n[j] = 1'b1;
      end

      // Known contents for the low addresses used by the random phase
      for (int j = 0; j < N; j++)
         for (int m = 0; m < 16; m++) wr(j, 8'(m), $urandom);

      // Load-and-read vectors, including the 0xFF wrap address
      tbl[0] = '{1, 8'h05, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[1] = '{0, 8'hFF, 32'hA5A5_0001, 32'hA5A5_0001};
      tbl[2] = '{3, 8'hFF, 32'h1234_5678, 32'h1234_5678};
      tbl[3] = '{2, 8'h00, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
      tbl[4] = '{0, 8'h7F, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      tbl[5] = '{3, 8'h01, 32'h0000_0000, 32'h0000_0000};
      tbl[6] = '{2, 8'h80, 32'h8000_0001, 32'h8000_0001};
      for (int j = 0; j < 7; j++) begin
         wr(tbl[j].k, tbl[j].a, tbl[j].d);
         rd(tbl[j].k, tbl[j].a, 0, -1, 8'h00, 32'd0, 32'd0);
         chk("tbl_data", tbl[j].k, data_out[tbl[j].k], tbl[j].exp);
      end

      // ce held high for 10 cycles after the response, then a second request
      wr(1, 8'h06, 32'h0606_0606);
      rd(1, 8'h05, 10, -1, 8'h00, 32'd0, 32'd0);
      rd(1, 8'h06, 0, -1, 8'h00, 32'd0, 32'd0);
      chk("held_second", 1, data_out[1], 32'h0606_0606);

      // Read/write collision: old word returned, later read sees the last write
      wr(1, 8'h10, 32'd1);
      rd(1, 8'h10, 0, 0, 8'h10, 32'd2, 32'd3);
      chk("coll_old", 1, data_out[1], 32'd1);
      rd(1, 8'h10, 0, -1, 8'h00, 32'd0, 32'd0);
      chk("coll_new", 1, data_out[1], 32'd3);

      // Abort on RD_LAT=4, then reset in the middle of a read, then recovery
      ab(2, 8'h00, 2, 0);
      chk("abort_hold", 2, data_out[2], 32'h8000_0001);
      ab(2, 8'h00, 0, 3);
      rd(2, 8'h80, 0, -1, 8'h00, 32'd0, 32'd0);
      chk("after_reset", 2, data_out[2], 32'h8000_0001);

      // Back-to-back at minimum spacing on the shortest and longest latency
      for (int j = 0; j < 6; j++) rd(0, 8'(j), 0, -1, 8'h00, 32'd0, 32'd0);
      for (int j = 0; j < 6; j++) rd(3, 8'(j + 6), 0, -1, 8'h00, 32'd0, 32'd0);

      // Randomized requests with writes in flight
      repeat (150) begin
         k    = int'($urandom_range(0, N - 1));
         a    = 8'($urandom_range(0, 15));
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
         wat  = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, LATS[k] - 1));
         wa   = ($urandom_range(0, 1) == 1) ? a : 8'($urandom_range(0, 15));
         rd(k, a, hold, wat, wa, $urandom, $urandom);
      end

      // Counter saturation
      @(negedge clk);
      force g_dut[1].u.resp_cnt_q = 16'hFFFE;
      #1;
      release g_dut[1].u.resp_cnt_q;
      expcnt[1] = 65534;
      @(negedge clk);
      chk("sat_preload", 1, 32'(resp_cnt[1]), 32'h0000_FFFE);
      repeat (3) rd(1, 8'h05, 0, -1, 8'h00, 32'd0, 32'd0);
      chk("sat_final", 1, 32'(resp_cnt[1]), 32'h0000_FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
